// File: rtl/csr_access_ctrl_if.sv
// Bundle between csr_access_ctrl and decode, mcsr, writeback and trap_ctrl.
// master is the controller's view; slave is everything around it.
interface csr_access_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   csr_req;
  logic                   csr_req_ready;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [DATA_WIDTH-1:0]  rs1_data;
  logic                   flush;
  logic [11:0]            csr_addr;
  logic                   mcsr_rd;
  logic                   mcsr_wr;
  logic                   valid_mcsr_rd;
  logic                   valid_mcsr_wr;
  logic                   mcsr_set;
  logic                   mcsr_clr;
  logic [DATA_WIDTH-1:0]  write_data;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   csr_illegal_access;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [4:0]             wb_rd_idx;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   illegal_trap;
  logic [INSTR_WIDTH-1:0] illegal_instr;
  logic                   busy;

  modport master (
    input  csr_req, instr_in, rs1_data, flush,
    input  read_data, csr_illegal_access, wb_ready,
    output csr_req_ready, csr_addr,
    output mcsr_rd, mcsr_wr,
    output valid_mcsr_rd, valid_mcsr_wr,
    output mcsr_set, mcsr_clr, write_data,
    output wb_valid, wb_rd_idx, wb_data,
    output illegal_trap, illegal_instr, busy
  );

  modport slave (
    output csr_req, instr_in, rs1_data, flush,
    output read_data, csr_illegal_access, wb_ready,
    input  csr_req_ready, csr_addr,
    input  mcsr_rd, mcsr_wr,
    input  valid_mcsr_rd, valid_mcsr_wr,
    input  mcsr_set, mcsr_clr, write_data,
    input  wb_valid, wb_rd_idx, wb_data,
    input  illegal_trap, illegal_instr, busy
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Zicsr sequencer: read phase, separate modify-write phase, then writeback
// of the old CSR value or a one-cycle illegal-instruction trap request.
module csr_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input logic               cpu_clk,
  input logic               cpu_rstn,
  csr_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_WR,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [INSTR_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0]  r_operand;
  logic                   r_do_rd;
  logic                   r_do_wr;
  logic [DATA_WIDTH-1:0]  r_wb_data;
  logic                   r_trap;
  logic [INSTR_WIDTH-1:0] r_trap_instr;

  logic [2:0]            w_in_f3;
  logic [4:0]            w_in_rs1;
  logic [4:0]            w_in_rd;
  logic                  w_in_rw;
  logic                  w_in_rs;
  logic                  w_in_rc;
  logic                  w_in_ok;
  logic                  w_in_do_rd;
  logic                  w_in_do_wr;
  logic [DATA_WIDTH-1:0] w_in_operand;
  logic                  w_accept;

  assign w_in_f3  = bus.instr_in[14:12];
  assign w_in_rs1 = bus.instr_in[19:15];
  assign w_in_rd  = bus.instr_in[11:7];

  always_comb begin
    w_in_rw = 1'b0;
    w_in_rs = 1'b0;
    w_in_rc = 1'b0;
    unique case (w_in_f3)
      3'b001, 3'b101: w_in_rw = 1'b1;
      3'b010, 3'b110: w_in_rs = 1'b1;
      3'b011, 3'b111: w_in_rc = 1'b1;
      default: ;
    endcase
  end

  // bad f3 leaves both intents clear so mcsr sees no access at all
  assign w_in_ok    = w_in_rw | w_in_rs | w_in_rc;
  assign w_in_do_rd = w_in_ok & ~(w_in_rw & (w_in_rd == 5'd0));
  assign w_in_do_wr = w_in_rw
                    | ((w_in_rs | w_in_rc) & (w_in_rs1 != 5'd0));

  assign w_in_operand = w_in_f3[2]
    ? {{(DATA_WIDTH-5){1'b0}}, w_in_rs1}
    : bus.rs1_data;

  assign w_accept = bus.csr_req & (r_state == S_IDLE) & ~bus.flush;

  logic [2:0] w_f3;
  logic [4:0] w_rd;
  logic       w_set;
  logic       w_clr;
  logic       w_f3_ok;
  logic       w_illegal;

  assign w_f3 = r_instr[14:12];
  assign w_rd = r_instr[11:7];

  always_comb begin
    w_set   = 1'b0;
    w_clr   = 1'b0;
    w_f3_ok = 1'b0;
    unique case (w_f3)
      3'b001, 3'b101: w_f3_ok = 1'b1;
      3'b010, 3'b110: begin
        w_f3_ok = 1'b1;
        w_set   = 1'b1;
      end
      3'b011, 3'b111: begin
        w_f3_ok = 1'b1;
        w_clr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_illegal = bus.csr_illegal_access
                   | ~w_f3_ok
                   | ~(r_do_rd | r_do_wr);

  logic                  w_mcsr_rd;
  logic                  w_mcsr_wr;
  logic                  w_vld_rd;
  logic                  w_vld_wr;
  logic                  w_mset;
  logic                  w_mclr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_wb_valid;
  logic [4:0]            w_wb_rd;
  logic [DATA_WIDTH-1:0] w_wb_data_nxt;
  logic                  w_trap_nxt;

  always_comb begin
    w_next        = r_state;
    w_mcsr_rd     = 1'b0;
    w_mcsr_wr     = 1'b0;
    w_vld_rd      = 1'b0;
    w_vld_wr      = 1'b0;
    w_mset        = 1'b0;
    w_mclr        = 1'b0;
    w_wdata       = '0;
    w_wb_valid    = 1'b0;
    w_wb_rd       = 5'd0;
    w_wb_data_nxt = r_wb_data;
    w_trap_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ACC;
      end
      S_ACC: begin
        w_mcsr_rd     = r_do_rd;
        w_mcsr_wr     = r_do_wr;
        w_vld_rd      = r_do_rd & ~bus.flush;
        w_wb_data_nxt = r_do_rd ? bus.read_data : '0;
        if (bus.flush) begin
          w_next = S_IDLE;
        end else if (w_illegal) begin
          w_trap_nxt = 1'b1;
          w_next     = S_IDLE;
        end else if (r_do_wr) begin
          w_next = S_WR;
        end else if (w_rd != 5'd0) begin
          w_next = S_WB;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR: begin
        w_mcsr_wr = 1'b1;
        w_vld_wr  = ~bus.flush;
        w_mset    = w_set;
        w_mclr    = w_clr;
        w_wdata   = r_operand;
        if (!bus.flush && w_rd != 5'd0) w_next = S_WB;
        else                            w_next = S_IDLE;
      end
      S_WB: begin
        w_wb_valid = ~bus.flush;
        w_wb_rd    = w_rd;
        if (bus.flush || bus.wb_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_operand    <= '0;
      r_do_rd      <= 1'b0;
      r_do_wr      <= 1'b0;
      r_wb_data    <= '0;
      r_trap       <= 1'b0;
      r_trap_instr <= '0;
    end else begin
      r_state      <= w_next;
      r_wb_data    <= w_wb_data_nxt;
      r_trap       <= w_trap_nxt;
      r_trap_instr <= w_trap_nxt ? r_instr : '0;
      if (w_accept) begin
        r_instr   <= bus.instr_in;
        r_operand <= w_in_operand;
        r_do_rd   <= w_in_do_rd;
        r_do_wr   <= w_in_do_wr;
      end
    end
  end

  assign bus.csr_req_ready = (r_state == S_IDLE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.csr_addr      = r_instr[31:20];
  assign bus.mcsr_rd       = w_mcsr_rd;
  assign bus.mcsr_wr       = w_mcsr_wr;
  assign bus.valid_mcsr_rd = w_vld_rd;
  assign bus.valid_mcsr_wr = w_vld_wr;
  assign bus.mcsr_set      = w_mset;
  assign bus.mcsr_clr      = w_mclr;
  assign bus.write_data    = w_wdata;
  assign bus.wb_valid      = w_wb_valid;
  assign bus.wb_rd_idx     = w_wb_rd;
  assign bus.wb_data       = r_wb_data;
  assign bus.illegal_trap  = r_trap;
  assign bus.illegal_instr = r_trap_instr;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: mcsr model, writeback/trap scoreboard,
// vector table plus hand sequences for stall, flush and reset corners.
module tb_csr_access_ctrl;

  logic clk;
  logic cpu_rstn;

  csr_access_ctrl_if #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  csr_access_ctrl #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .cpu_clk  (clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // mcsr model: read-only CSRs (addr[11:10]==11) reject writes
  logic [31:0] csr_mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_val = '0;
  int          wr_cnt = 0;

  assign bus.read_data = bus.mcsr_rd ? csr_mem[bus.csr_addr] : 32'h0;
  assign bus.csr_illegal_access =
    bus.mcsr_wr && (bus.csr_addr[11:10] == 2'b11);

  always @(posedge clk) begin
    if (pl_en) begin
      csr_mem[pl_addr] <= pl_val;
    end else if (bus.valid_mcsr_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.mcsr_set)
        csr_mem[bus.csr_addr] <= csr_mem[bus.csr_addr] | bus.write_data;
      else if (bus.mcsr_clr)
        csr_mem[bus.csr_addr] <= csr_mem[bus.csr_addr] & ~bus.write_data;
      else
        csr_mem[bus.csr_addr] <= bus.write_data;
    end
  end

  typedef struct {
    logic        is_trap;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  ev_t sbq[$];

  always @(negedge clk) begin
    if (cpu_rstn) begin
      if ((bus.wb_valid && bus.wb_ready) || bus.illegal_trap) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got wb=%0d trap=%0d need none",
                   bus.wb_valid, bus.illegal_trap);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          if (bus.illegal_trap)
            chk("sb_event", {25'd0, 1'b1, 5'd0, bus.illegal_instr},
                {25'd0, e.is_trap, e.rd, e.data});
          else
            chk("sb_event", {25'd0, 1'b0, bus.wb_rd_idx, bus.wb_data},
                {25'd0, e.is_trap, e.rd, e.data});
        end
      end
      if (!bus.illegal_trap)
        chk("instr_zero", 64'(bus.illegal_instr), 64'd0);
      chk("set_clr_excl", 64'(bus.mcsr_set & bus.mcsr_clr), 64'd0);
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] init;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
    int          idle;
    int          nwr;
    logic [31:0] after;
  } vec_t;

  vec_t vt [9];

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    pl_addr = a;
    pl_val  = v;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic push_ev(input logic t, input logic [4:0] rd,
                         input logic [31:0] d);
    ev_t e;
    e.is_trap = t;
    e.rd      = rd;
    e.data    = d;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r1);
    bus.instr_in = ins;
    bus.rs1_data = r1;
    bus.csr_req  = 1'b1;
    @(posedge clk);
    #1;
    bus.csr_req  = 1'b0;
    bus.instr_in = '0;
    bus.rs1_data = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [11:0] a;
    int k_ev;
    int k_idle;
    int w0;
    a = v.instr[31:20];
    preload(a, v.init);
    w0 = wr_cnt;
    if (v.kind == 2'd1) push_ev(1'b0, v.rd, v.data);
    if (v.kind == 2'd2) push_ev(1'b1, 5'd0, v.data);
    issue(v.instr, v.rs1);
    k_ev   = 0;
    k_idle = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k_ev == 0 && (bus.wb_valid || bus.illegal_trap)) k_ev = k;
      if (k_idle == 0 && !bus.busy) k_idle = k;
    end
    $display("vector %0d instr=%h", idx, v.instr);
    chk("latency", 64'(k_ev), 64'(v.lat));
    chk("idle_at", 64'(k_idle), 64'(v.idle));
    chk("csr_after", 64'(csr_mem[a]), 64'(v.after));
    chk("writes", 64'(wr_cnt - w0), 64'(v.nwr));
  endtask

  initial begin
    int w0;
    vt[0] = '{32'h300092F3, 32'h8, 32'h0, 2'd1, 5'd5, 32'h0,
              3, 4, 1, 32'h8};
    vt[1] = '{32'h30502373, 32'hFFFF, 32'h100, 2'd1, 5'd6, 32'h100,
              2, 3, 0, 32'h100};
    vt[2] = '{32'hF1109073, 32'h5, 32'hABCD, 2'd2, 5'd0, 32'hF1109073,
              2, 2, 0, 32'hABCD};
    vt[3] = '{32'h300473F3, 32'h0, 32'h88, 2'd1, 5'd7, 32'h88,
              3, 4, 1, 32'h80};
    vt[4] = '{32'h340121F3, 32'hF0, 32'h0F, 2'd1, 5'd3, 32'h0F,
              3, 4, 1, 32'hFF};
    vt[5] = '{32'h340FD073, 32'hDEAD, 32'h12345678, 2'd0, 5'd0, 32'h0,
              0, 3, 1, 32'h1F};
    vt[6] = '{32'h34014173, 32'h7, 32'h55, 2'd2, 5'd0, 32'h34014173,
              2, 2, 0, 32'h55};
    vt[7] = '{32'h340230F3, 32'h0F, 32'hFF, 2'd1, 5'd1, 32'hFF,
              3, 4, 1, 32'hF0};
    vt[8] = '{32'h340064F3, 32'h99, 32'hAB, 2'd1, 5'd9, 32'hAB,
              2, 3, 0, 32'hAB};

    bus.csr_req  = 1'b0;
    bus.instr_in = '0;
    bus.rs1_data = '0;
    bus.flush    = 1'b0;
    bus.wb_ready = 1'b1;
    cpu_rstn     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.csr_req_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_outs", 64'({bus.wb_valid, bus.illegal_trap, bus.mcsr_rd,
                         bus.mcsr_wr, bus.valid_mcsr_rd,
                         bus.valid_mcsr_wr}), 64'd0);
    chk("rst_addr", 64'(bus.csr_addr), 64'd0);
    chk("rst_wbdata", 64'(bus.wb_data), 64'd0);
    @(posedge clk);
    #1 cpu_rstn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // writeback stall on csrrci x7,mstatus,8
    preload(12'h300, 32'h88);
    push_ev(1'b0, 5'd7, 32'h88);
    bus.wb_ready = 1'b0;
    issue(32'h300473F3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_wr_clr", 64'({bus.valid_mcsr_wr, bus.mcsr_clr,
                             bus.mcsr_set}), 64'b110);
    chk("stall_wdata", 64'(bus.write_data), 64'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wbv", 64'(bus.wb_valid), 64'd1);
      chk("stall_wbd", 64'(bus.wb_data), 64'h88);
      chk("stall_rdy", 64'(bus.csr_req_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_idle", 64'(bus.busy), 64'd0);
    chk("stall_csr", 64'(csr_mem[12'h300]), 64'h80);

    // flush in ACC, then back-to-back accept
    preload(12'h300, 32'h55);
    w0 = wr_cnt;
    issue(32'h300092F3, 32'h8);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("facc_vrd", 64'(bus.valid_mcsr_rd), 64'd0);
    chk("facc_rd", 64'(bus.mcsr_rd), 64'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    push_ev(1'b0, 5'd6, 32'h100);
    bus.instr_in = 32'h30502373;
    bus.csr_req  = 1'b1;
    @(negedge clk);
    chk("facc_b2b_rdy", 64'(bus.csr_req_ready), 64'd1);
    @(posedge clk);
    #1 bus.csr_req = 1'b0;
    @(negedge clk);
    chk("facc_b2b_busy", 64'(bus.busy), 64'd1);
    repeat (4) @(negedge clk);
    chk("facc_nowr", 64'(wr_cnt - w0), 64'd0);
    chk("facc_csr", 64'(csr_mem[12'h300]), 64'h55);

    // flush beats csr_req in IDLE
    @(posedge clk);
    #1;
    bus.flush    = 1'b1;
    bus.instr_in = 32'h30502373;
    bus.csr_req  = 1'b1;
    @(posedge clk);
    #1;
    bus.flush   = 1'b0;
    bus.csr_req = 1'b0;
    @(negedge clk);
    chk("fidle_busy", 64'(bus.busy), 64'd0);

    // flush in WR
    w0 = wr_cnt;
    issue(32'h300092F3, 32'h8);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("fwr_vwr", 64'({bus.mcsr_wr, bus.valid_mcsr_wr}), 64'b10);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("fwr_idle", 64'(bus.busy), 64'd0);
    chk("fwr_nowr", 64'(wr_cnt - w0), 64'd0);

    // flush in WB drops wb_valid
    issue(32'h30502373, 32'h0);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("fwb_wbv", 64'(bus.wb_valid), 64'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("fwb_idle", 64'(bus.busy), 64'd0);

    // reset during WR
    preload(12'h300, 32'h11);
    issue(32'h300092F3, 32'h8);
    @(negedge clk);
    @(negedge clk);
    chk("rwr_vwr", 64'(bus.valid_mcsr_wr), 64'd1);
    #1 cpu_rstn = 1'b0;
    #1;
    chk("rwr_drop", 64'({bus.valid_mcsr_wr, bus.busy, bus.wb_valid}),
        64'd0);
    @(posedge clk);
    #1 cpu_rstn = 1'b1;
    @(negedge clk);
    chk("rwr_ready", 64'(bus.csr_req_ready), 64'd1);
    chk("rwr_csr", 64'(csr_mem[12'h300]), 64'h11);
    repeat (3) @(negedge clk);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Sequences one Zicsr instruction at a time into the machine CSR file (mcsr) for the single in-order pipeline.
- Accepts an instruction from decode via valid/ready and checks legality.
- Runs the read phase, then the modify-write phase as a separate step.
- Returns the old CSR value to writeback, or raises an illegal-instruction trap request to trap_ctrl.
- Sole driver of every mcsr access strobe.

Parameters:
DATA_WIDTH, 32, CSR data and rs1 width
INSTR_WIDTH, 32, instruction width

Ports:
cpu_clk  in  1  cpu clock
cpu_rstn  in  1  asynchronous reset, active low
csr_req  in  1  decode presents a SYSTEM/CSR instruction
csr_req_ready  out  1  controller can accept
instr_in  in  INSTR_WIDTH  instruction word
rs1_data  in  DATA_WIDTH  rs1 operand, valid with csr_req
flush  in  1  pipeline flush (trap/redirect)
csr_addr  out  12  CSR address to mcsr
mcsr_rd  out  1  read intent (legality check)
mcsr_wr  out  1  write intent (legality check)
valid_mcsr_rd  out  1  committed read
valid_mcsr_wr  out  1  committed write
mcsr_set  out  1  set-bits write
mcsr_clr  out  1  clear-bits write
write_data  out  DATA_WIDTH  write/set/clear operand
read_data  in  DATA_WIDTH  mcsr read data
csr_illegal_access  in  1  mcsr legality result (combinational)
wb_valid  out  1  writeback result valid
wb_ready  in  1  writeback accepts
wb_rd_idx  out  5  destination register
wb_data  out  DATA_WIDTH  old CSR value
illegal_trap  out  1  one-cycle illegal-instruction request
illegal_instr  out  INSTR_WIDTH  offending instruction, zero when illegal_trap=0
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock cpu_clk. Reset is asynchronous, active-low on cpu_rstn.
- Reset values: state=IDLE. All registered outputs are 0. csr_req_ready=1.
- Decode fields:
  - f3 = instr[14:12]; rs1/uimm = instr[19:15]; rd = instr[11:7]; csr = instr[31:20].
  - f3 001=RW, 010=RS, 011=RC, 101=RWI, 110=RSI, 111=RCI. f3 000/100 are illegal.
- do_rd = !(RW/RWI && rd==0).
- do_wr = RW/RWI, or (RS/RC/RSI/RCI with rs1/uimm != 0).
- Operand: register forms use rs1_data; immediate forms use {27'b0, uimm}. Captured at accept.
- Accept: csr_req & csr_req_ready latches instr, operand, do_rd, do_wr. Goes to ACC next cycle.
- csr_req_ready = (state==IDLE).
- States:
  - IDLE: no strobes.
  - ACC:
    - Drive csr_addr, mcsr_rd=do_rd, mcsr_wr=do_wr, valid_mcsr_rd=do_rd & !flush.
    - Capture read_data into wb_data if do_rd, else capture 0.
    - Illegal if csr_illegal_access, or bad f3, or both do_rd and do_wr are 0 (impossible, guard only).
    - Illegal: pulse illegal_trap and drive illegal_instr with the latched instr next cycle, then go to IDLE. No write, no writeback.
    - Legal: next is WR if do_wr; else WB if rd!=0; else IDLE.
  - WR:
    - mcsr_wr=1, valid_mcsr_wr = !flush.
    - mcsr_set = RS/RSI, mcsr_clr = RC/RCI (never both). write_data = operand.
    - Next is WB if rd!=0, else IDLE.
  - WB:
    - wb_valid=1, wb_rd_idx=rd, wb_data held stable until wb_ready.
    - wb_valid & wb_ready: go to IDLE.
- Outside the relevant states, mcsr_rd, mcsr_wr, valid_*, set, clr and write_data are 0. csr_addr holds its last value.
- Latency from accept to mcsr and writeback:
  - Read+write: ACC at T+1, write at T+2, wb_valid at T+3.
  - Read-only: wb_valid at T+2.
  - rd=0 write: back to IDLE at T+3.
- Flush:
  - In ACC or WR: the valid_* strobes are gated off in that same cycle. No illegal_trap, no writeback. IDLE next cycle.
  - In WB: drop wb_valid, go to IDLE.
  - In IDLE: flush beats csr_req, so no accept that cycle.
- Read uses pre-write value: CSRRS/CSRRC return the value before modification. The write is never in the same cycle as the read.
- Reset mid-operation: immediate return to IDLE. Any pending write or writeback is lost.

Test Plan:
1. csrrw x5,mstatus,x1 (0x300092F3), rs1_data=0x8, mstatus=0 → ACC reads 0x0; WR valid_mcsr_wr=1, set=clr=0, write_data=0x8; wb_valid rd=5 data=0x0 at T+3.
2. csrrs x6,mtvec,x0 (0x30502373), mtvec=0x100 → read only, valid_mcsr_wr never asserted; wb_data=0x100 at T+2.
3. csrrw x0,mvendorid,x1 (0xF1109073) → csr_illegal_access in ACC; illegal_trap pulse at T+2 with illegal_instr=0xF1109073; no valid_mcsr_wr, no wb_valid.
4. csrrci x7,mstatus,8 (0x300473F3), mstatus=0x88 → wb_data=0x88; WR mcsr_clr=1, write_data=0x8; hold wb_ready=0 for 3 cycles → wb_valid and wb_data stable, csr_req_ready=0.
5. Flush asserted in the ACC cycle of test 1 → valid_mcsr_rd=0 that cycle, no write, no writeback; back-to-back csr_req accepted the next cycle.
6. Assert cpu_rstn=0 during WR → valid_mcsr_wr drops immediately, busy=0; first cycle after release csr_req_ready=1.
